twiddle_sequencer: RTL and testbench

- Initiator side of the twiddle ROM lookup interface; drives index k and size n into twiddle_factor_unified and streams one twiddle per radix-2 DIT butterfly to the butterfly datapath.
- Walks all log2(N) stages × N/2 butterflies of one FFT run per start pulse.
- Ready/valid output with one-entry registered output stage.

---
 rtl/fft_pkg.sv | 20 ++
 rtl/twseq_out_reg.sv | 32 +++
 rtl/twiddle_sequencer.sv | 115 +++++++++++
 tb/tb_twiddle_sequencer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT sizing constants, precision encoding, sequencer states and helpers.
package fft_pkg;
    localparam int MAX_N      = 1024;
    localparam int ADDR_WIDTH = 10;
    localparam int FP4        = 0;
    localparam int FP8        = 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic logic is_pow2(input logic [31:0] v);
        return v != 0 && (v & (v - 32'd1)) == 0;
    endfunction

    function automatic int clog2(input logic [31:0] v);
        int r = 0;
        for (int i = 0; i < 32; i++)
            if ((32'd1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/twseq_out_reg.sv
// twseq_out_reg: one-entry ready/valid output register for twiddle, stage and butterfly index.
module twseq_out_reg #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          ready,
    input  logic [15:0]   next_data,
    input  logic [AW-1:0] next_stage,
    input  logic [AW-2:0] next_bfly,
    output logic          valid,
    output logic [15:0]   data,
    output logic [AW-1:0] stage,
    output logic [AW-2:0] bfly
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            stage <= '0;
            bfly  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= next_data;
            stage <= next_stage;
            bfly  <= next_bfly;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/twiddle_sequencer.sv
// twiddle_sequencer: walks all radix-2 DIT stages/butterflies, addressing the twiddle ROM.
// Optional TWSEQ_STALL_CNT_EN adds a saturating backpressure cycle counter stall_cnt.
module twiddle_sequencer
    import fft_pkg::*;
#(
    parameter int MAX_N      = fft_pkg::MAX_N,
    parameter int ADDR_WIDTH = fft_pkg::ADDR_WIDTH,
    parameter int PRECISION  = fft_pkg::FP4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   n_cfg,
    output logic [ADDR_WIDTH-1:0] rom_k,
    output logic [ADDR_WIDTH:0]   rom_n,
    input  logic [15:0]           rom_data,
    output logic                  tw_valid,
    input  logic                  tw_ready,
    output logic [15:0]           twiddle_out,
    output logic [ADDR_WIDTH-1:0] tw_stage,
    output logic [ADDR_WIDTH-2:0] tw_bfly,
    output logic                  busy,
    output logic                  done,
`ifdef TWSEQ_STALL_CNT_EN
    output logic [15:0]           stall_cnt,
`endif
    output logic                  err
);
    localparam logic [ADDR_WIDTH-1:0] S_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-2:0] J_ONE = (ADDR_WIDTH-1)'(1);

    // PRECISION belongs to the ROM; only its encoding is sanity-checked here.
    if (PRECISION != FP4 && PRECISION != FP8) begin : g_bad_precision
        $error("twiddle_sequencer: PRECISION must be FP4 or FP8");
    end

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] s, s_nx, last_s;
    logic [ADDR_WIDTH-2:0] j, j_nx, j_max;
    logic                  n_ok, go, adv, last;

    assign n_ok = is_pow2(32'(n_cfg)) && n_cfg >= (ADDR_WIDTH+1)'(2) && n_cfg <= (ADDR_WIDTH+1)'(MAX_N);
    assign go   = start && state == IDLE && n_ok;
    assign adv  = state == RUN && (!tw_valid || tw_ready);
    assign last = s == last_s && j == j_max;
    assign j_nx = j == j_max ? '0 : j + J_ONE;
    assign s_nx = j == j_max ? s + S_ONE : s;
    assign busy = state != IDLE;
    assign done = state == DRAIN && tw_valid && tw_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = go ? RUN : IDLE;
            RUN:     state_nx = adv && last ? DRAIN : RUN;
            DRAIN:   state_nx = tw_valid && tw_ready ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    // ROM address is registered alongside the counters so it never depends on inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s      <= '0;
            j      <= '0;
            last_s <= '0;
            j_max  <= '0;
            rom_k  <= '0;
            rom_n  <= '0;
            err    <= 1'b0;
        end else begin
            err <= start && state == IDLE && !n_ok;
            if (go) begin
                s      <= '0;
                j      <= '0;
                last_s <= ADDR_WIDTH'(clog2(32'(n_cfg)) - 1);
                j_max  <= (ADDR_WIDTH-1)'((n_cfg >> 1) - (ADDR_WIDTH+1)'(1));
                rom_k  <= '0;
                rom_n  <= (ADDR_WIDTH+1)'(2);
            end else if (adv && !last) begin
                s     <= s_nx;
                j     <= j_nx;
                rom_k <= ADDR_WIDTH'(j_nx) & ((S_ONE << s_nx) - S_ONE);
                rom_n <= (ADDR_WIDTH+1)'(2) << s_nx;
            end
        end
    end

    twseq_out_reg #(.AW(ADDR_WIDTH)) u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (adv),
        .ready      (tw_ready),
        .next_data  (rom_data),
        .next_stage (s),
        .next_bfly  (j),
        .valid      (tw_valid),
        .data       (twiddle_out),
        .stage      (tw_stage),
        .bfly       (tw_bfly)
    );

`ifdef TWSEQ_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                             stall_cnt <= '0;
        else if (go)                                            stall_cnt <= '0;
        else if (tw_valid && !tw_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_twiddle_sequencer.sv
// tb_twiddle_sequencer: table-driven runs with random backpressure against a stage/butterfly model.
module tb_twiddle_sequencer;
    logic        clk = 0;
    logic        rst_n, start, tw_ready, tw_valid, busy, done, err;
    logic [10:0] n_cfg, rom_n;
    logic [9:0]  rom_k, tw_stage;
    logic [8:0]  tw_bfly;
    logic [15:0] rom_data, twiddle_out;
`ifdef TWSEQ_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    // Stand-in ROM: a distinct code per (k, n) so any addressing error shows in twiddle_out.
    function automatic logic [15:0] rom_f(input int k, input int n);
        return 16'(k + 37 * n);
    endfunction

    always_comb rom_data = rom_f(int'(rom_k), int'(rom_n));

    twiddle_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_cfg(n_cfg),
        .rom_k(rom_k), .rom_n(rom_n), .rom_data(rom_data),
        .tw_valid(tw_valid), .tw_ready(tw_ready), .twiddle_out(twiddle_out),
        .tw_stage(tw_stage), .tw_bfly(tw_bfly), .busy(busy), .done(done),
`ifdef TWSEQ_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .err(err)
    );

    typedef struct {int stage; int bfly; int k; int n;} exp_t;
    typedef struct {int n; bit exp_err; int exp_cnt; int pct; int hold0; int abort_at;} vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, tw_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rom_k"}, rom_k, 0);
        chk({tag, "_rom_n"}, rom_n, 0);
        chk({tag, "_twiddle"}, twiddle_out, 0);
        chk({tag, "_stage"}, tw_stage, 0);
        chk({tag, "_bfly"}, tw_bfly, 0);
    endtask

    task automatic run(input vec_t v);
        exp_t q[$];
        exp_t e;
        int acc = 0, it = 0, first = -1, stalls = 0, p_tw = 0, p_st = 0, p_bf = 0, p_k = 0, p_n = 0;
        bit fin = 0, err_seen = 0, prev_stall = 0;
        for (int st = 0; (2 << st) <= v.n; st++)
            for (int b = 0; b < v.n / 2; b++)
                q.push_back('{st, b, b % (1 << st), 2 << st});
        @(posedge clk); #1;
        start = 1; n_cfg = 11'(v.n);
        @(posedge clk); #1;
        start = 0;
        chk("err_pulse", err, int'(v.exp_err));
        chk("busy_after_start", busy, int'(!v.exp_err));
        chk("valid_after_start", tw_valid, 0);
        if (v.exp_err) begin
            repeat (3) begin
                @(posedge clk); #1;
                chk("err_single_cycle", err, 0);
                chk("idle_after_err", busy, 0);
                chk("no_twiddle_after_err", tw_valid, 0);
            end
            return;
        end
        chk("first_rom_k", rom_k, 0);
        chk("first_rom_n", rom_n, 2);
        while (!fin && it < 4 * v.n * 11 + 40) begin
            it++;
            @(posedge clk); #1;
            tw_ready = it <= v.hold0 ? 1'b0 : ($urandom_range(99) < v.pct);
            start = it == 1;
            n_cfg = 11'd3;
            @(negedge clk);
            err_seen |= err;
            if (tw_valid && first < 0) first = it;
            if (prev_stall) begin
                chk("stall_valid_held", tw_valid, 1);
                chk("stall_twiddle_stable", twiddle_out, p_tw);
                chk("stall_stage_stable", tw_stage, p_st);
                chk("stall_bfly_stable", tw_bfly, p_bf);
                chk("stall_rom_k_stable", rom_k, p_k);
                chk("stall_rom_n_stable", rom_n, p_n);
            end
            prev_stall = tw_valid && !tw_ready;
            if (prev_stall) stalls++;
            p_tw = twiddle_out; p_st = tw_stage; p_bf = tw_bfly; p_k = rom_k; p_n = rom_n;
            if (tw_valid && tw_ready) begin
                if (q.size() == 0) begin
                    chk("extra_twiddle", tw_valid, 0);
                    fin = 1;
                end else begin
                    e = q.pop_front();
                    acc++;
                    chk("tw_stage", tw_stage, e.stage);
                    chk("tw_bfly", tw_bfly, e.bfly);
                    chk("twiddle_out", twiddle_out, rom_f(e.k, e.n));
                    chk("done_on_last", done, int'(q.size() == 0));
                    if (q.size() == 0) begin
                        fin = 1;
`ifdef TWSEQ_STALL_CNT_EN
                        chk("stall_cnt", stall_cnt, stalls);
`endif
                    end
                end
            end else if (done) begin
                chk("done_without_accept", done, 0);
            end
            if (v.abort_at != 0 && acc == v.abort_at) begin
                rst_n = 0;
                #1;
                chk_zero_outputs("abort");
                @(posedge clk); #1;
                rst_n = 1; start = 0;
                return;
            end
        end
        chk("twiddle_count", acc, v.exp_cnt);
        chk("first_valid_latency", first, 1);
        chk("start_while_busy_err", err_seen, 0);
        @(posedge clk); #1;
        start = 0;
        chk("busy_after_done", busy, 0);
        chk("valid_after_done", tw_valid, 0);
        chk("done_single_cycle", done, 0);
        chk("err_after_run", err, 0);
    endtask

    vec_t vecs[14];

    initial begin
        vecs = '{
            '{8,    0, 12,  100, 0, 0},
            '{2,    0, 1,   100, 0, 0},
            '{16,   0, 32,  50,  0, 0},
            '{12,   1, 0,   100, 0, 0},
            '{2048, 1, 0,   100, 0, 0},
            '{0,    1, 0,   100, 0, 0},
            '{1,    1, 0,   100, 0, 0},
            '{6,    1, 0,   100, 0, 0},
            '{4,    0, 4,   60,  0, 0},
            '{32,   0, 80,  40,  0, 0},
            '{1024, 0, 0,   80,  0, 300},
            '{4,    0, 4,   100, 0, 0},
            '{8,    0, 12,  100, 5, 0},
            '{64,   0, 192, 70,  0, 0}
        };
        rst_n = 0; start = 0; n_cfg = '0; tw_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        chk("reset_err", err, 0);
        rst_n = 1;
        for (int i = 0; i < 14; i++) run(vecs[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
